id_ex_stage_reg: RTL and testbench

- Pipeline register between the decode-stage controller and the execute stage.
- Captures the decoded control word, operands, immediates and register tags each cycle. Presents them registered to the ALU/branch logic.
- Supports hazard freeze (hold), branch flush (bubble insert) and a valid bit, so execute and hazard logic can ignore bubbles.

---
 rtl/id_ex_stage_reg.sv | 172 +++++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_reg
// Brief    : Decode-to-execute pipeline register with freeze, flush and valid.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage_reg #(
   parameter int WORD_WIDTH = 32,
   parameter int REG_ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  freeze,
   input  logic                  valid_in,
   input  logic [3:0]            execute_command_in,
   input  logic                  mem_read_in,
   input  logic                  mem_write_in,
   input  logic                  wb_enable_in,
   input  logic                  branch_taken_in,
   input  logic                  status_write_enable_in,
   input  logic                  immediate_in,
   input  logic [WORD_WIDTH-1:0] pc_in,
   input  logic [WORD_WIDTH-1:0] val_rn_in,
   input  logic [WORD_WIDTH-1:0] val_rm_in,
   input  logic [11:0]           shift_operand_in,
   input  logic [23:0]           signed_imm_24_in,
   input  logic [REG_ADDR_W-1:0] dest_in,
   input  logic [REG_ADDR_W-1:0] src1_in,
   input  logic [REG_ADDR_W-1:0] src2_in,
   input  logic [3:0]            status_in,
   output logic                  valid_out,
   output logic [3:0]            execute_command_out,
   output logic                  mem_read_out,
   output logic                  mem_write_out,
   output logic                  wb_enable_out,
   output logic                  branch_taken_out,
   output logic                  status_write_enable_out,
   output logic                  immediate_out,
   output logic [WORD_WIDTH-1:0] pc_out,
   output logic [WORD_WIDTH-1:0] val_rn_out,
   output logic [WORD_WIDTH-1:0] val_rm_out,
   output logic [11:0]           shift_operand_out,
   output logic [23:0]           signed_imm_24_out,
   output logic [REG_ADDR_W-1:0] dest_out,
   output logic [REG_ADDR_W-1:0] src1_out,
   output logic [REG_ADDR_W-1:0] src2_out,
   output logic [3:0]            status_out
);

   logic                  valid_d,        valid_q;
   logic [3:0]            exe_cmd_d,      exe_cmd_q;
   logic                  mem_read_d,     mem_read_q;
   logic                  mem_write_d,    mem_write_q;
   logic                  wb_enable_d,    wb_enable_q;
   logic                  branch_taken_d, branch_taken_q;
   logic                  status_we_d,    status_we_q;
   logic                  immediate_d,    immediate_q;
   logic [WORD_WIDTH-1:0] pc_d,           pc_q;
   logic [WORD_WIDTH-1:0] val_rn_d,       val_rn_q;
   logic [WORD_WIDTH-1:0] val_rm_d,       val_rm_q;
   logic [11:0]           shift_op_d,     shift_op_q;
   logic [23:0]           simm24_d,       simm24_q;
   logic [REG_ADDR_W-1:0] dest_d,         dest_q;
   logic [REG_ADDR_W-1:0] src1_d,         src1_q;
   logic [REG_ADDR_W-1:0] src2_d,         src2_q;
   logic [3:0]            status_d,       status_q;

   // Side effects are gated by slot validity; a flush clears validity outright.
   logic side_ok;
   assign side_ok = valid_in & ~flush;

   always_comb begin
      valid_d        = valid_q;
      exe_cmd_d      = exe_cmd_q;
      mem_read_d     = mem_read_q;
      mem_write_d    = mem_write_q;
      wb_enable_d    = wb_enable_q;
      branch_taken_d = branch_taken_q;
      status_we_d    = status_we_q;
      immediate_d    = immediate_q;
      pc_d           = pc_q;
      val_rn_d       = val_rn_q;
      val_rm_d       = val_rm_q;
      shift_op_d     = shift_op_q;
      simm24_d       = simm24_q;
      dest_d         = dest_q;
      src1_d         = src1_q;
      src2_d         = src2_q;
      status_d       = status_q;

      if (flush || !freeze) begin
         valid_d        = side_ok;
         exe_cmd_d      = flush ? 4'b0000 : execute_command_in;
         mem_read_d     = mem_read_in & side_ok;
         mem_write_d    = mem_write_in & side_ok;
         wb_enable_d    = wb_enable_in & side_ok;
         branch_taken_d = branch_taken_in & side_ok;
         status_we_d    = status_write_enable_in & side_ok;
         immediate_d    = immediate_in;
         pc_d           = pc_in;
         val_rn_d       = val_rn_in;
         val_rm_d       = val_rm_in;
         shift_op_d     = shift_operand_in;
         simm24_d       = signed_imm_24_in;
         dest_d         = dest_in;
         src1_d         = src1_in;
         src2_d         = src2_in;
         status_d       = status_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q        <= 1'b0;
         exe_cmd_q      <= 4'b0000;
         mem_read_q     <= 1'b0;
         mem_write_q    <= 1'b0;
         wb_enable_q    <= 1'b0;
         branch_taken_q <= 1'b0;
         status_we_q    <= 1'b0;
         immediate_q    <= 1'b0;
         pc_q           <= '0;
         val_rn_q       <= '0;
         val_rm_q       <= '0;
         shift_op_q     <= '0;
         simm24_q       <= '0;
         dest_q         <= '0;
         src1_q         <= '0;
         src2_q         <= '0;
         status_q       <= '0;
      end else begin
         valid_q        <= valid_d;
         exe_cmd_q      <= exe_cmd_d;
         mem_read_q     <= mem_read_d;
         mem_write_q    <= mem_write_d;
         wb_enable_q    <= wb_enable_d;
         branch_taken_q <= branch_taken_d;
         status_we_q    <= status_we_d;
         immediate_q    <= immediate_d;
         pc_q           <= pc_d;
         val_rn_q       <= val_rn_d;
         val_rm_q       <= val_rm_d;
         shift_op_q     <= shift_op_d;
         simm24_q       <= simm24_d;
         dest_q         <= dest_d;
         src1_q         <= src1_d;
         src2_q         <= src2_d;
         status_q       <= status_d;
      end
   end

   assign valid_out               = valid_q;
   assign execute_command_out     = exe_cmd_q;
   assign mem_read_out            = mem_read_q;
   assign mem_write_out           = mem_write_q;
   assign wb_enable_out           = wb_enable_q;
   assign branch_taken_out        = branch_taken_q;
   assign status_write_enable_out = status_we_q;
   assign immediate_out           = immediate_q;
   assign pc_out                  = pc_q;
   assign val_rn_out              = val_rn_q;
   assign val_rm_out              = val_rm_q;
   assign shift_operand_out       = shift_op_q;
   assign signed_imm_24_out       = simm24_q;
   assign dest_out                = dest_q;
   assign src1_out                = src1_q;
   assign src2_out                = src2_q;
   assign status_out              = status_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage_reg
// Brief    : Self-checking bench for id_ex_stage_reg against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage_reg;

   typedef struct packed {
      logic        valid;
      logic [3:0]  cmd;
      logic        mem_read;
      logic        mem_write;
      logic        wb;
      logic        br;
      logic        swe;
      logic        imm;
      logic [31:0] pc;
      logic [31:0] rn;
      logic [31:0] rm;
      logic [11:0] shift;
      logic [23:0] simm;
      logic [3:0]  dest;
      logic [3:0]  src1;
      logic [3:0]  src2;
      logic [3:0]  status;
   } entry_t;

   logic   clk = 1'b0;
   logic   rst = 1'b0;
   logic   flush = 1'b0;
   logic   freeze = 1'b0;
   entry_t drv = '0;
   entry_t dut_o;
   entry_t exp_e = '0;
   entry_t msk;
   bit     exp_cmd_dc = 1'b0;
   int     n_cmp = 0;
   int     n_err = 0;

   logic        o_valid, o_mr, o_mw, o_wb, o_br, o_swe, o_imm;
   logic [3:0]  o_cmd, o_dest, o_src1, o_src2, o_status;
   logic [31:0] o_pc, o_rn, o_rm;
   logic [11:0] o_shift;
   logic [23:0] o_simm;

   always #5 clk = ~clk;

   id_ex_stage_reg #(.WORD_WIDTH(32), .REG_ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
      .valid_in(drv.valid), .execute_command_in(drv.cmd),
      .mem_read_in(drv.mem_read), .mem_write_in(drv.mem_write),
      .wb_enable_in(drv.wb), .branch_taken_in(drv.br),
      .status_write_enable_in(drv.swe), .immediate_in(drv.imm),
      .pc_in(drv.pc), .val_rn_in(drv.rn), .val_rm_in(drv.rm),
      .shift_operand_in(drv.shift), .signed_imm_24_in(drv.simm),
      .dest_in(drv.dest), .src1_in(drv.src1), .src2_in(drv.src2),
      .status_in(drv.status),
      .valid_out(o_valid), .execute_command_out(o_cmd),
      .mem_read_out(o_mr), .mem_write_out(o_mw), .wb_enable_out(o_wb),
      .branch_taken_out(o_br), .status_write_enable_out(o_swe),
      .immediate_out(o_imm), .pc_out(o_pc), .val_rn_out(o_rn),
      .val_rm_out(o_rm), .shift_operand_out(o_shift),
      .signed_imm_24_out(o_simm), .dest_out(o_dest), .src1_out(o_src1),
      .src2_out(o_src2), .status_out(o_status)
   );

   assign dut_o = {o_valid, o_cmd, o_mr, o_mw, o_wb, o_br, o_swe, o_imm,
                   o_pc, o_rn, o_rm, o_shift, o_simm, o_dest, o_src1, o_src2, o_status};

   // What the stage should hold after one edge, stated from the pipeline rules.
   function automatic entry_t model_next(entry_t prev, entry_t in, bit fl, bit fz);
      entry_t n;
      if (!fl && fz) return prev;
      n = in;
      if (fl || !in.valid) begin
         n.valid = 1'b0; n.mem_read = 1'b0; n.mem_write = 1'b0;
         n.wb = 1'b0; n.br = 1'b0; n.swe = 1'b0;
      end
      if (fl) n.cmd = 4'b0000;
      return n;
   endfunction

   always_comb begin
      msk = '1;
      if (exp_cmd_dc) msk.cmd = 4'b0000;
   end

   task automatic step();
      if (flush || !freeze) exp_cmd_dc = !flush && !drv.valid;
      exp_e = model_next(exp_e, drv, flush, freeze);
      @(posedge clk);
      #1;
   endtask

   task automatic rand_inputs();
      drv = {$urandom, $urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic test_reset();
      drv = '1; flush = 1'b0; freeze = 1'b0;
      #2 rst = 1'b1;
      step(); step();
      #3 rst = 1'b0;
      #1;
      n_cmp++;
      if (dut_o !== '0) begin
         n_err++; $display("FAIL reset_async: got %h need 0", dut_o);
      end
      #1 rst = 1'b1;
      exp_e = '0; exp_cmd_dc = 1'b0;
      step();
      n_cmp++;
      if (o_cmd !== 4'b1111 || o_rn !== 32'hFFFF_FFFF || o_valid !== 1'b1) begin
         n_err++; $display("FAIL reset_release: cmd=%b rn=%h valid=%b need 1111 ffffffff 1", o_cmd, o_rn, o_valid);
      end
      n_cmp++;
      if ((dut_o & msk) !== (exp_e & msk)) begin
         n_err++; $display("FAIL reset_release_all: got %h need %h", dut_o, exp_e);
      end
      // reset in the middle of a freeze
      freeze = 1'b1; rand_inputs(); step();
      #3 rst = 1'b0;
      #1;
      n_cmp++;
      if (dut_o !== '0) begin
         n_err++; $display("FAIL reset_mid_freeze: got %h need 0", dut_o);
      end
      #1 rst = 1'b1;
      freeze = 1'b0; exp_e = '0; exp_cmd_dc = 1'b0;
   endtask

   task automatic test_normal_load();
      drv = '0; drv.valid = 1'b1; drv.cmd = 4'b0010; drv.wb = 1'b1;
      drv.rn = 32'h5; drv.dest = 4'd3;
      step();
      n_cmp++;
      if (o_cmd !== 4'b0010 || o_wb !== 1'b1 || o_rn !== 32'h5 || o_dest !== 4'd3 || o_valid !== 1'b1) begin
         n_err++; $display("FAIL load_add: got %h need cmd=2 wb=1 rn=5 dest=3", dut_o);
      end
      drv.cmd = 4'b0100; drv.rn = 32'h9; drv.dest = 4'd7;
      step();
      n_cmp++;
      if (o_cmd !== 4'b0100 || o_rn !== 32'h9 || o_dest !== 4'd7) begin
         n_err++; $display("FAIL load_sub: got %h need cmd=4 rn=9 dest=7", dut_o);
      end
      n_cmp++;
      if ((dut_o & msk) !== (exp_e & msk)) begin
         n_err++; $display("FAIL load_sub_all: got %h need %h", dut_o, exp_e);
      end
   endtask

   task automatic test_freeze();
      drv = '0; drv.valid = 1'b1; drv.mem_read = 1'b1; drv.wb = 1'b1; drv.pc = 32'h10;
      step();
      freeze = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_inputs(); step();
         n_cmp++;
         if (o_pc !== 32'h10 || o_mr !== 1'b1 || o_wb !== 1'b1 || o_valid !== 1'b1) begin
            n_err++; $display("FAIL freeze_hold[%0d]: got %h need pc=10 mr=1 wb=1 valid=1", i, dut_o);
         end
      end
      freeze = 1'b0; rand_inputs(); drv.valid = 1'b1;
      step();
      n_cmp++;
      if (dut_o !== drv) begin
         n_err++; $display("FAIL freeze_release: got %h need %h", dut_o, drv);
      end
   endtask

   task automatic test_flush();
      rand_inputs(); drv.valid = 1'b1; drv.mem_write = 1'b1;
      flush = 1'b1;
      step();
      n_cmp++;
      if (o_valid !== 1'b0 || o_mw !== 1'b0 || o_cmd !== 4'b0000 || o_pc !== drv.pc) begin
         n_err++; $display("FAIL flush_bubble: got %h need valid=0 mw=0 cmd=0 pc=%h", dut_o, drv.pc);
      end
      flush = 1'b0; rand_inputs(); drv.valid = 1'b1;
      step();
      n_cmp++;
      if (dut_o !== drv) begin
         n_err++; $display("FAIL flush_after: got %h need %h", dut_o, drv);
      end
   endtask

   task automatic test_flush_freeze();
      rand_inputs(); drv.valid = 1'b1; drv.wb = 1'b1;
      flush = 1'b1; freeze = 1'b1;
      step();
      n_cmp++;
      if (o_valid !== 1'b0 || o_wb !== 1'b0 || o_simm !== drv.simm) begin
         n_err++; $display("FAIL flush_freeze: got %h need valid=0 wb=0 simm=%h", dut_o, drv.simm);
      end
      flush = 1'b0; freeze = 1'b0;
   endtask

   task automatic test_invalid_slot();
      rand_inputs(); drv.valid = 1'b0; drv.br = 1'b1; drv.swe = 1'b1;
      drv.simm = 24'h000ABC;
      step();
      n_cmp++;
      if (o_br !== 1'b0 || o_swe !== 1'b0 || o_valid !== 1'b0 || o_simm !== 24'h000ABC) begin
         n_err++; $display("FAIL invalid_slot: br=%b swe=%b valid=%b simm=%h need 0 0 0 000abc", o_br, o_swe, o_valid, o_simm);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rand_inputs();
         flush  = ($urandom_range(0, 4) == 0);
         freeze = ($urandom_range(0, 3) == 0);
         step();
         n_cmp++;
         if ((dut_o & msk) !== (exp_e & msk)) begin
            n_err++; $display("FAIL random[%0d]: got %h need %h", i, dut_o, exp_e);
         end
      end
      flush = 1'b0; freeze = 1'b0;
   endtask

   initial begin
      test_reset();
      test_normal_load();
      test_freeze();
      test_flush();
      test_flush_freeze();
      test_invalid_slot();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
